// File: rtl/hdmi_frame_gate.sv
// hdmi_frame_gate
//   Frame qualifier between the DVI receiver and the DMA write port, running
//   on the received pixel clock. It measures each frame's active width and
//   height and repacks RGB888 to RGB565. Pixels are forwarded (out_de) only
//   after LOCK_FRAMES consecutive frames of exactly H_DISP x V_DISP, so the
//   frame buffer never sees partial or wrong-mode frames after a hot-plug
//   or a mode change.
//
// Ports
//   clk, rst            pixel clock, asynchronous active-high reset
//   enable              gate enable, only looked at on frame boundaries
//   in_vs, in_de        input sync/enable (in_vs polarity set by VS_POL)
//   in_r/in_g/in_b      RGB888 input pixel
//   out_vs              active-high vsync, 1 cycle delay
//   out_de              gated data enable, 1 cycle delay
//   out_data            RGB565 pixel, 1 cycle delay
//   locked              high while the gate is passing frames
//   meas_h, meas_v      last line length / line count of the previous frame
//   frame_err           1-cycle pulse when a bad frame closes while locked
module hdmi_frame_gate #(
  parameter logic [11:0] H_DISP      = 12'd1280,
  parameter logic [11:0] V_DISP      = 12'd720,
  parameter logic        VS_POL      = 1'b1,
  parameter int          LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        in_vs,
  input  logic        in_de,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  output logic        out_vs,
  output logic        out_de,
  output logic [15:0] out_data,
  output logic        locked,
  output logic [11:0] meas_h,
  output logic [11:0] meas_v,
  output logic        frame_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEEK  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_PASS  = 2'd3;

  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);
  localparam logic [11:0] SAT    = 12'hFFF;

  logic [1:0]  state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic        vs_prev_q, de_prev_q;
  logic [11:0] pix_q, pix_d;
  logic [11:0] line_q, line_d;
  logic [11:0] len_q, len_d;
  logic        bad_q, bad_d;
  logic        skip_q, skip_d;
  logic        pass_q;
  logic        err_d;
  logic        out_vs_q, out_de_q, err_q;
  logic [15:0] out_data_q;
  logic [11:0] meas_h_q, meas_v_q;

  logic        vs_n, fb, line_end, cnt_line, skip_now;
  logic [11:0] pix_inc, line_inc, lines_close, len_close;
  logic        bad_close;

  assign vs_n     = (in_vs == VS_POL);
  assign fb       = vs_n & ~vs_prev_q;
  assign line_end = de_prev_q & ~in_de;
  // A run that was already active at the frame boundary belongs to no frame.
  assign cnt_line = line_end & ~skip_q;
  assign skip_now = skip_q | (fb & in_de);

  assign pix_inc  = (pix_q  == SAT) ? pix_q  : pix_q  + 12'd1;
  assign line_inc = (line_q == SAT) ? line_q : line_q + 12'd1;

  // Closing-frame view at a boundary: a line ending on the boundary cycle
  // still belongs to the frame being closed.
  assign lines_close = cnt_line ? line_inc : line_q;
  assign len_close   = cnt_line ? pix_q    : len_q;
  assign bad_close   = bad_q | (cnt_line & (pix_q != H_DISP)) | in_de |
                       (lines_close != V_DISP);

  // Measurement counters
  always_comb begin
    pix_d  = pix_q;
    line_d = line_q;
    len_d  = len_q;
    bad_d  = bad_q;
    skip_d = skip_q;
    if (fb) begin
      pix_d  = '0;
      line_d = '0;
      len_d  = '0;
      bad_d  = 1'b0;
      skip_d = in_de;
    end else begin
      if (line_end)              pix_d = '0;
      else if (in_de & ~skip_q)  pix_d = pix_inc;
      if (cnt_line) begin
        line_d = line_inc;
        len_d  = pix_q;
        if (pix_q != H_DISP) bad_d = 1'b1;
      end
      if (line_end) skip_d = 1'b0;
    end
  end

  // Lock FSM, advances only on frame boundaries
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    if (fb) begin
      case (state_q)
        ST_IDLE: if (enable) state_d = ST_SEEK;
        // First frame after enabling is partial: skip evaluation.
        ST_SEEK: state_d = enable ? ST_CHECK : ST_IDLE;
        ST_CHECK: begin
          if (!enable) begin
            state_d = ST_IDLE;
            good_d  = '0;
          end else if (bad_close) begin
            good_d  = '0;
          end else begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 >= LOCK_N) state_d = ST_PASS;
          end
        end
        default: begin
          err_d = bad_close;
          if (!enable) begin
            state_d = ST_IDLE;
            good_d  = '0;
          end else if (bad_close) begin
            state_d = ST_CHECK;
            good_d  = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      good_q     <= '0;
      vs_prev_q  <= 1'b0;
      de_prev_q  <= 1'b0;
      pix_q      <= '0;
      line_q     <= '0;
      len_q      <= '0;
      bad_q      <= 1'b0;
      skip_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 1'b0;
      meas_h_q   <= '0;
      meas_v_q   <= '0;
      out_vs_q   <= 1'b0;
      out_de_q   <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      vs_prev_q  <= vs_n;
      de_prev_q  <= in_de;
      pix_q      <= pix_d;
      line_q     <= line_d;
      len_q      <= len_d;
      bad_q      <= bad_d;
      skip_q     <= skip_d;
      err_q      <= err_d;
      if (fb) begin
        // Gating decision is frozen for the whole upcoming frame.
        pass_q   <= (state_d == ST_PASS);
        meas_h_q <= len_close;
        meas_v_q <= lines_close;
      end
      out_vs_q   <= vs_n;
      out_de_q   <= in_de & pass_q & ~skip_now;
      out_data_q <= {in_r[7:3], in_g[7:2], in_b[7:3]};
    end
  end

  assign out_vs    = out_vs_q;
  assign out_de    = out_de_q;
  assign out_data  = out_data_q;
  assign locked    = (state_q == ST_PASS);
  assign meas_h    = meas_h_q;
  assign meas_v    = meas_v_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_hdmi_frame_gate.sv
// Directed/randomised bench for hdmi_frame_gate with a frame-level reference
// model (line lengths kept in a queue, evaluated at each frame boundary).
module tb_hdmi_frame_gate;
  localparam logic [11:0] H  = 12'd8;
  localparam logic [11:0] V  = 12'd4;
  localparam int          LK = 2;

  localparam int M_IDLE = 0, M_SEEK = 1, M_CHECK = 2, M_PASS = 3;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, vs = 1'b0, de = 1'b0;
  logic [7:0]  r = '0, g = '0, b = '0;
  logic        in_vs_n;
  logic        out_vs, out_de, locked, frame_err;
  logic [15:0] out_data;
  logic [11:0] meas_h, meas_v;
  logic        out_vs2, out_de2, locked2, frame_err2;
  logic [15:0] out_data2;
  logic [11:0] meas_h2, meas_v2;

  assign in_vs_n = ~vs;

  hdmi_frame_gate #(.H_DISP(H), .V_DISP(V), .VS_POL(1'b1), .LOCK_FRAMES(LK)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_vs(vs), .in_de(de),
    .in_r(r), .in_g(g), .in_b(b), .out_vs(out_vs), .out_de(out_de),
    .out_data(out_data), .locked(locked), .meas_h(meas_h), .meas_v(meas_v),
    .frame_err(frame_err));

  // Same stream with inverted vsync into a VS_POL=0 instance.
  hdmi_frame_gate #(.H_DISP(H), .V_DISP(V), .VS_POL(1'b0), .LOCK_FRAMES(LK)) dut_n (
    .clk(clk), .rst(rst), .enable(enable), .in_vs(in_vs_n), .in_de(de),
    .in_r(r), .in_g(g), .in_b(b), .out_vs(out_vs2), .out_de(out_de2),
    .out_data(out_data2), .locked(locked2), .meas_h(meas_h2), .meas_v(meas_v2),
    .frame_err(frame_err2));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int vectors = 0, miscompares = 0;
  logic en_req = 1'b0;

  // reference model state
  int   st, gc, run;
  bit   m_vsp, m_dep, m_skip, m_pass;
  int   lens[$];
  bit   e_vs, e_de, e_lock, e_err;
  logic [15:0] e_data;
  int   e_mh, e_mv;

  task automatic chk1(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk1("out_vs",    16'(out_vs),    16'(e_vs));
    chk1("out_de",    16'(out_de),    16'(e_de));
    chk1("out_data",  out_data,       e_data);
    chk1("locked",    16'(locked),    16'(e_lock));
    chk1("meas_h",    16'(meas_h),    16'(e_mh));
    chk1("meas_v",    16'(meas_v),    16'(e_mv));
    chk1("frame_err", 16'(frame_err), 16'(e_err));
    chk1("pol0_vs",   16'(out_vs2),   16'(e_vs));
    chk1("pol0_lock", 16'(locked2),   16'(e_lock));
  endtask

  task automatic model_reset();
    st = M_IDLE; gc = 0; run = 0;
    m_vsp = 0; m_dep = 0; m_skip = 0; m_pass = 0;
    lens.delete();
    e_vs = 0; e_de = 0; e_lock = 0; e_err = 0; e_data = '0; e_mh = 0; e_mv = 0;
  endtask

  // Predicts the outputs after the next rising edge for the given inputs.
  task automatic model_step(input bit v, input bit d, input bit en,
                            input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    bit fb, re, good;
    fb = v && !m_vsp;
    re = m_dep && !d;
    e_vs   = v;
    e_data = 16'((int'(rr) / 8) * 2048 + (int'(gg) / 4) * 32 + int'(bb) / 8);
    e_de   = d && m_pass && !(m_skip || (fb && d));
    e_err  = 0;
    if (re && !m_skip) lens.push_back(run);
    if (fb) begin
      good = !d && (lens.size() == int'(V));
      foreach (lens[i]) if (lens[i] != int'(H)) good = 0;
      e_mv = lens.size();
      e_mh = (lens.size() > 0) ? lens[lens.size()-1] : 0;
      case (st)
        M_IDLE:  if (en) st = M_SEEK;
        M_SEEK:  st = en ? M_CHECK : M_IDLE;
        M_CHECK: begin
          if (!en) begin st = M_IDLE; gc = 0; end
          else if (!good) gc = 0;
          else begin gc++; if (gc >= LK) st = M_PASS; end
        end
        default: begin
          if (!good) e_err = 1;
          if (!en) begin st = M_IDLE; gc = 0; end
          else if (!good) begin st = M_CHECK; gc = 0; end
        end
      endcase
      m_pass = (st == M_PASS);
      lens.delete();
      m_skip = d;
    end else if (re) begin
      m_skip = 0;
    end
    run    = (d && !m_skip) ? run + 1 : 0;
    e_lock = (st == M_PASS);
    m_vsp  = v;
    m_dep  = d;
  endtask

  task automatic step_px(input bit v, input bit d,
                         input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    @(negedge clk);
    check_all();
    vs = v; de = d; r = rr; g = gg; b = bb; enable = en_req;
    model_step(v, d, en_req, rr, gg, bb);
  endtask

  task automatic step(input bit v, input bit d);
    step_px(v, d, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // One frame: vsync, back porch, nl lines. Line odd_idx gets odd_len pixels.
  // de_at_fb: a run is already active when vsync rises (closing frame bad).
  // tight: last line has no trailing blank, so it ends on the next boundary.
  // drop_at: enable request cleared before that line.
  task automatic frame(input int nl, input int odd_idx, input int odd_len,
                       input bit de_at_fb, input bit tight, input int drop_at);
    int len;
    if (de_at_fb) begin
      step(0, 1); step(0, 1); step(1, 1); step(1, 1); step(0, 1); step(0, 0);
    end else begin
      step(1, 0); step(1, 0);
    end
    step(0, 0); step(0, 0);
    for (int i = 0; i < nl; i++) begin
      if (i == drop_at) en_req = 1'b0;
      len = (i == odd_idx) ? odd_len : int'(H);
      for (int j = 0; j < len; j++) step(0, 1);
      if (!(tight && i == nl - 1)) begin
        for (int k = 0; k < int'($urandom_range(2, 4)); k++) step(0, 0);
      end
    end
  endtask

  initial begin
    model_reset();
    #2;
    check_all();                       // reset values while rst held
    @(negedge clk);
    check_all();
    rst = 1'b0;
    model_step(0, 0, 0, 8'd0, 8'd0, 8'd0);

    // RGB565 packing while unlocked
    step_px(0, 0, 8'hFF, 8'h00, 8'hFF);
    #6;
    chk1("rgb565", out_data, 16'hF81F);

    // Acquire lock: IDLE->SEEK, partial frame, then LK good frames
    en_req = 1'b1;
    repeat (6) frame(int'(V), -1, 0, 0, 0, -1);
    chk1("locked_after_good", 16'(locked), 16'd1);
    chk1("meas_h_good",       16'(meas_h), 16'd8);
    chk1("meas_v_good",       16'(meas_v), 16'd4);

    // 9-pixel line while locked, then recovery
    frame(int'(V), 1, 9, 0, 0, -1);
    repeat (3) frame(int'(V), -1, 0, 0, 0, -1);

    // Short frame (3 lines) during CHECK after a bad frame
    frame(int'(V), 2, 7, 0, 0, -1);
    frame(3, -1, 0, 0, 0, -1);
    repeat (4) frame(int'(V), -1, 0, 0, 0, -1);

    // Line end coincident with frame boundary
    frame(int'(V), -1, 0, 0, 1, -1);
    repeat (2) frame(int'(V), -1, 0, 0, 0, -1);

    // Enable dropped mid-frame while locked, then re-enable
    frame(int'(V), -1, 0, 0, 0, 2);
    frame(int'(V), -1, 0, 0, 0, -1);
    chk1("idle_after_disable", 16'(locked), 16'd0);
    en_req = 1'b1;
    repeat (5) frame(int'(V), -1, 0, 0, 0, -1);

    // Frame boundary while de is high (skipped run), while locked
    frame(int'(V), -1, 0, 1, 0, -1);
    repeat (4) frame(int'(V), -1, 0, 0, 0, -1);

    // Asynchronous reset in the middle of a line
    step(1, 0); step(1, 0); step(0, 0);
    repeat (5) step(0, 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0; vs = 1'b0; de = 1'b0; enable = en_req;
    model_step(0, 0, en_req, r, g, b);
    repeat (5) frame(int'(V), -1, 0, 0, 0, -1);
    step(1, 0);
    step(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
